// File: rtl/seg_scroll_driver.sv
// Multiplexed N-digit 7-segment driver: circular message buffer, digit-refresh
// scan with anti-ghost blanking, and a timed bidirectional scroll.
module seg_scroll_driver #(
  parameter int DIGITS       = 4,
  parameter int MSG_LEN      = 16,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int SCROLL_DIV   = 5000000,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [4:0]        wr_data,
  input  logic              scroll_en,
  input  logic              scroll_dir,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic [AW-1:0]     pos,
  output logic              wrap
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] BLANK_LIM = RW'(BLANK_CYCLES);
  localparam logic [SW-1:0] SCR_LAST  = SW'(SCROLL_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam logic [AW-1:0] POS_LAST  = AW'(MSG_LEN - 1);
  localparam logic [AW:0]   LEN_EXT   = (AW+1)'(MSG_LEN);
  localparam logic [DIGITS-1:0] AN_FLIP  = {DIGITS{AN_ACT_LOW}};
  localparam logic [7:0]        SEG_FLIP = {8{SEG_ACT_LOW}};

  logic [RW-1:0]     ref_cnt_reg, ref_cnt_next;
  logic [DW-1:0]     dig_reg, dig_next;
  logic [SW-1:0]     scr_cnt_reg, scr_cnt_next;
  logic [AW-1:0]     pos_reg, pos_next;
  logic              wrap_reg, wrap_next;
  logic [DIGITS-1:0] an_reg, an_next;
  logic [7:0]        seg_reg, seg_next;

  logic [4:0]        buf_rd [MSG_LEN];
  logic [AW:0]       rd_sum;
  logic [AW-1:0]     rd_addr;
  logic [4:0]        rd_char;

  // One register per message entry so the whole buffer can be re-blanked on reset.
  generate
    for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_buf
      logic [4:0] char_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          char_reg <= 5'h10;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          char_reg <= wr_data;
        end
      end
      assign buf_rd[gi] = char_reg;
    end
  endgenerate

  function automatic logic [7:0] decode(input logic [4:0] code);
    logic [7:0] glyph;
    case (code)
      5'h00:   glyph = 8'h7E;
      5'h01:   glyph = 8'h30;
      5'h02:   glyph = 8'h6D;
      5'h03:   glyph = 8'h79;
      5'h04:   glyph = 8'h33;
      5'h05:   glyph = 8'h5B;
      5'h06:   glyph = 8'h5F;
      5'h07:   glyph = 8'h70;
      5'h08:   glyph = 8'h7F;
      5'h09:   glyph = 8'h7B;
      5'h0A:   glyph = 8'h77;
      5'h0B:   glyph = 8'h1F;
      5'h0C:   glyph = 8'h4E;
      5'h0D:   glyph = 8'h3D;
      5'h0E:   glyph = 8'h4F;
      5'h0F:   glyph = 8'h47;
      5'h11:   glyph = 8'h80;
      default: glyph = 8'h00;
    endcase
    return glyph;
  endfunction

  always_comb begin
    ref_cnt_next = ref_cnt_reg + 1'b1;
    dig_next     = dig_reg;
    if (ref_cnt_reg == REF_LAST) begin
      ref_cnt_next = '0;
      dig_next     = (dig_reg == DIG_LAST) ? '0 : dig_reg + 1'b1;
    end
  end

  // scroll_dir only matters on the step cycle itself.
  always_comb begin
    scr_cnt_next = scr_cnt_reg;
    pos_next     = pos_reg;
    wrap_next    = 1'b0;
    if (scroll_en) begin
      if (scr_cnt_reg == SCR_LAST) begin
        scr_cnt_next = '0;
        if (scroll_dir) begin
          if (pos_reg == '0) begin
            pos_next  = POS_LAST;
            wrap_next = 1'b1;
          end else begin
            pos_next = pos_reg - 1'b1;
          end
        end else begin
          if (pos_reg == POS_LAST) begin
            pos_next  = '0;
            wrap_next = 1'b1;
          end else begin
            pos_next = pos_reg + 1'b1;
          end
        end
      end else begin
        scr_cnt_next = scr_cnt_reg + 1'b1;
      end
    end
  end

  assign rd_sum  = {1'b0, pos_reg} + (AW+1)'(dig_reg);
  assign rd_addr = (rd_sum >= LEN_EXT) ? AW'(rd_sum - LEN_EXT) : rd_sum[AW-1:0];
  assign rd_char = buf_rd[rd_addr];

  always_comb begin
    an_next  = '0;
    seg_next = 8'h00;
    if (ref_cnt_reg >= BLANK_LIM) begin
      an_next[dig_reg] = 1'b1;
      seg_next         = decode(rd_char);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt_reg <= '0;
      dig_reg     <= '0;
      scr_cnt_reg <= '0;
      pos_reg     <= '0;
      wrap_reg    <= 1'b0;
      an_reg      <= AN_FLIP;
      seg_reg     <= SEG_FLIP;
    end else begin
      ref_cnt_reg <= ref_cnt_next;
      dig_reg     <= dig_next;
      scr_cnt_reg <= scr_cnt_next;
      pos_reg     <= pos_next;
      wrap_reg    <= wrap_next;
      an_reg      <= an_next ^ AN_FLIP;
      seg_reg     <= seg_next ^ SEG_FLIP;
    end
  end

  assign an   = an_reg;
  assign seg  = seg_reg;
  assign pos  = pos_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_seg_scroll_driver.sv
// Scoreboard bench for seg_scroll_driver: stimulus queues expected digit slots
// and scroll steps, a negedge monitor pops and compares them as the DUT shows them.
module tb_seg_scroll_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic       scroll_en = 1'b0;
  logic       scroll_dir = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic [2:0] pos;
  logic       wrap;

  seg_scroll_driver #(
    .DIGITS(4), .MSG_LEN(8), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .SCROLL_DIV(16), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .an(an), .seg(seg), .pos(pos), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] an; logic [7:0] seg; int blank; } slot_t;
  typedef struct { logic [2:0] pos; logic wrap; } step_t;

  slot_t slot_q[$];
  step_t step_q[$];
  int    total = 0;
  int    bad = 0;
  bit    chk_on = 1'b0;
  int    en_edges = 0;

  // Enabled scroll edges seen by the DUT; each step must take exactly 16.
  initial forever begin
    @(posedge clk);
    if (reset && scroll_en) en_edges++;
  end

  initial begin
    logic [3:0] prev_an;
    logic [2:0] prev_pos;
    int blank_run;
    int pos_mark;
    slot_t se;
    step_t pe;
    prev_an = 4'hF; prev_pos = 3'd0; blank_run = 0; pos_mark = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_an = 4'hF; blank_run = 0; prev_pos = pos; pos_mark = en_edges;
      end else begin
        total++;
        if ($countones(~an) > 1) begin
          bad++; $display("FAIL onehot: an=%b, required at most one active anode", an);
        end
        if (an == 4'hF) begin
          total++;
          if (seg !== 8'hFF) begin
            bad++; $display("FAIL blank_seg: seg=%h while all anodes off, required ff", seg);
          end
          blank_run++;
        end else if (prev_an == 4'hF) begin
          if (chk_on) begin
            total++;
            if (slot_q.size() == 0) begin
              bad++; $display("FAIL slot_unexpected: an=%b seg=%h, required no slot", an, seg);
            end else begin
              se = slot_q.pop_front();
              if (an !== se.an || seg !== se.seg || (se.blank != 0 && blank_run != se.blank)) begin
                bad++;
                $display("FAIL slot: got an=%b seg=%h blank=%0d, required an=%b seg=%h blank=%0d",
                         an, seg, blank_run, se.an, se.seg, se.blank);
              end else begin
                $display("slot an=%b seg=%h blank=%0d ok", an, seg, blank_run);
              end
            end
          end
          blank_run = 0;
        end
        prev_an = an;

        if (pos !== prev_pos) begin
          total++;
          if (step_q.size() == 0) begin
            bad++; $display("FAIL step_unexpected: pos %0d->%0d, required no change", prev_pos, pos);
          end else begin
            pe = step_q.pop_front();
            if (pos !== pe.pos || wrap !== pe.wrap || (en_edges - pos_mark) != 16) begin
              bad++;
              $display("FAIL step: got pos=%0d wrap=%b gap=%0d, required pos=%0d wrap=%b gap=16",
                       pos, wrap, en_edges - pos_mark, pe.pos, pe.wrap);
            end else begin
              $display("step pos=%0d wrap=%b gap=%0d ok", pos, wrap, en_edges - pos_mark);
            end
          end
          pos_mark = en_edges;
        end else begin
          total++;
          if (wrap !== 1'b0) begin
            bad++; $display("FAIL stray_wrap: wrap=%b with pos held at %0d, required 0", wrap, pos);
          end
        end
        prev_pos = pos;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL %s: got=%h required=%h", name, got, exp);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  task automatic push_slot(input logic [3:0] a, input logic [7:0] s, input int b);
    slot_t e;
    e.an = a; e.seg = s; e.blank = b;
    slot_q.push_back(e);
  endtask

  task automatic push_step(input logic [2:0] p, input logic w);
    step_t e;
    e.pos = p; e.wrap = w;
    step_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Call at posedge+1; the write lands on the next edge.
  task automatic write(input logic [2:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((slot_q.size() != 0 || step_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    total++;
    if (slot_q.size() != 0 || step_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d slot and %0d step entries left, required 0",
               name, slot_q.size(), step_q.size());
      slot_q.delete(); step_q.delete();
    end
  endtask

  // Returns at the negedge showing the blank cycle right before digit 0 lights.
  task automatic sync_dig0(input string name);
    bit seen = 1'b0;
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); n++;
      if (an == 4'b0111) seen = 1'b1;
      else if (seen && an == 4'hF) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL %s_sync: an=%b, required digit-3 slot then blank within 40 cycles", name, an);
    end
  endtask

  initial begin
    int n;
    // Reset state and blank scan after release.
    #22;
    check("rst_an", 32'(an), 32'h0F);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_pos", 32'(pos), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    push_slot(4'b1110, 8'hFF, 0);
    push_slot(4'b1101, 8'hFF, 1);
    push_slot(4'b1011, 8'hFF, 1);
    push_slot(4'b0111, 8'hFF, 1);
    chk_on = 1'b1;
    reset = 1'b1;
    drain("reset_scan", 40);
    chk_on = 1'b0;

    // Load 0..7, scroll held.
    tick();
    for (int i = 0; i < 8; i++) write(3'(i), 5'(i));
    sync_dig0("load");
    push_slot(4'b1110, 8'h81, 1);
    push_slot(4'b1101, 8'hCF, 1);
    push_slot(4'b1011, 8'h92, 1);
    push_slot(4'b0111, 8'h86, 1);
    chk_on = 1'b1;
    drain("load_scan", 40);
    chk_on = 1'b0;
    check("pos_hold", 32'(pos), 32'h0);

    // Scroll left to pos 6, freeze, look at the window 6,7,0,1.
    for (int p = 1; p <= 6; p++) push_step(3'(p), 1'b0);
    tick();
    scroll_en = 1'b1;
    drain("scroll_up", 200);
    tick();
    scroll_en = 1'b0;
    sync_dig0("pos6");
    push_slot(4'b1110, 8'hA0, 1);
    push_slot(4'b1101, 8'h8F, 1);
    push_slot(4'b1011, 8'h81, 1);
    push_slot(4'b0111, 8'hCF, 1);
    chk_on = 1'b1;
    drain("pos6_scan", 40);
    chk_on = 1'b0;
    check("pos_frozen", 32'(pos), 32'h6);

    // Resume, wrap forward, then reverse with a mid-count freeze.
    push_step(3'd7, 1'b0);
    push_step(3'd0, 1'b1);
    tick();
    scroll_en = 1'b1;
    drain("wrap_up", 100);
    tick();
    scroll_dir = 1'b1;
    push_step(3'd7, 1'b1);
    drain("wrap_down", 60);
    repeat (5) tick();
    scroll_en = 1'b0;
    repeat (20) tick();
    push_step(3'd6, 1'b0);
    scroll_en = 1'b1;
    drain("resume", 60);
    tick();
    scroll_en = 1'b0;
    check("pos_after_dn", 32'(pos), 32'h6);

    // Point and out-of-table codes.
    tick();
    write(3'd6, 5'h11);
    write(3'd7, 5'h1F);
    sync_dig0("codes");
    push_slot(4'b1110, 8'h7F, 1);
    push_slot(4'b1101, 8'hFF, 1);
    push_slot(4'b1011, 8'h81, 1);
    push_slot(4'b0111, 8'hCF, 1);
    chk_on = 1'b1;
    drain("codes_scan", 40);
    chk_on = 1'b0;

    // Overwrite the glyph currently lit on digit 0.
    sync_dig0("live_wr");
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 5'h03;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("live_old_an", 32'(an), 32'hE);
    check("live_old_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    check("live_new_an", 32'(an), 32'hE);
    check("live_new_seg", 32'(seg), 32'h86);

    // Asynchronous reset in a lit slot, then a fully blank buffer.
    n = 0;
    while (an == 4'hF && n < 20) begin
      @(negedge clk); n++;
    end
    check("lit_before_rst", 32'(an == 4'hF), 32'h0);
    #2 reset = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'h0F);
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_pos", 32'(pos), 32'h0);
    check("arst_wrap", 32'(wrap), 32'h0);
    push_slot(4'b1110, 8'hFF, 0);
    push_slot(4'b1101, 8'hFF, 1);
    push_slot(4'b1011, 8'hFF, 1);
    push_slot(4'b0111, 8'hFF, 1);
    chk_on = 1'b1;
    @(negedge clk); #1;
    reset = 1'b1;
    drain("reblank_scan", 40);
    chk_on = 1'b0;
    check("pos_after_rst", 32'(pos), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
